dct_block_loader: RTL and testbench
===================================

DCT_BLOCK_LOADER -- requirements
Module: dct_block_loader

Interface
REQ-001 The block SHALL expose parameter PIX_W, default 8, giving the unsigned input pixel width.
REQ-002 The block SHALL expose parameter LEVEL_SHIFT, default 128, giving the offset subtracted from every pixel.
REQ-003 The block SHALL have port clock  input  1  the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port pix_in  input  PIX_W  unsigned pixel, raster order within an 8x8 block.
REQ-006 The block SHALL have port pix_valid  input  1  pix_in valid.
REQ-007 The block SHALL have port pix_ready  output  1  loader can accept pix_in.
REQ-008 The block SHALL have port x  output  64x(PIX_W+1), packed signed  block to DCT; element k at bits [9k+8:9k] for PIX_W=8.
REQ-009 The block SHALL have port IN_START  output  1  one-cycle start pulse to DCT.
REQ-010 The block SHALL have port OUT_XFC  input  1  DCT transform-complete pulse.
REQ-011 The block SHALL have port blk_count  output  16  count of blocks dispatched.

Function
REQ-012 A pixel SHALL be accepted only in a cycle with pix_valid=1 and pix_ready=1; nothing else advances the write index.
REQ-013 The block SHALL hold two 64-entry buffers (ping-pong), a 6-bit write index, write select, read select and one full flag per buffer.
REQ-014 An accepted pixel at write index k SHALL be stored as pix_in - LEVEL_SHIFT, sign-extended to PIX_W+1 bits (range -128..127 for defaults), into entry k of the write-select buffer.
REQ-015 Accepting index 63 SHALL set that buffer's full flag, toggle write select and wrap the index to 0 on the same edge.
REQ-016 pix_ready SHALL equal NOT full[write select], from registered state only; it SHALL be 0 while rst_=0.
REQ-017 The dispatch FSM SHALL have states IDLE, START, WAIT; IN_START SHALL be 1 exactly when the state is START.
REQ-018 IDLE -> START when full[read select]=1; START -> WAIT unconditionally; WAIT -> IDLE on OUT_XFC=1, clearing full[read select], toggling read select.
REQ-019 x SHALL present buffer[read select] unchanged from the START cycle through the cycle OUT_XFC is sampled in WAIT.
REQ-020 IN_START SHALL assert in the second cycle after the cycle in which index 63 is accepted, when the FSM is IDLE with the other buffer empty.
REQ-021 blk_count SHALL increment on each START cycle and wrap 65535 -> 0.
REQ-022 OUT_XFC in IDLE or START SHALL be ignored.
REQ-023 Fill-complete and OUT_XFC in the same cycle SHALL both take effect on that edge; a freed buffer raises pix_ready the following cycle.
REQ-024 Blocks SHALL be dispatched strictly in fill order; no partial block SHALL ever be dispatched.

Reset
REQ-025 With rst_=0 at a rising edge, the block SHALL clear write index, write/read select, both full flags and blk_count, and enter IDLE.
REQ-026 During and after reset, IN_START SHALL be 0; x SHALL be 0 until the first dispatch; a partially filled block SHALL be discarded.

Verification
REQ-027 Reset, then 64 pixels of 128 back-to-back -> IN_START high for one cycle, two cycles after the last pixel; all x[k]=0; blk_count=1.
REQ-028 Ramp pix_in=4k, k=0..63 -> x[0]=-128, x[1]=-124, x[63]=124; x stable until OUT_XFC.
REQ-029 Three blocks, pix_valid constant, OUT_XFC withheld -> pix_ready drops after pixel 128 and stays 0; one OUT_XFC pulse -> pix_ready=1 next cycle, IN_START for block 2 two cycles after OUT_XFC, blk_count=2.
REQ-030 pix_valid toggling every cycle over 128 cycles -> one block of 64 pixels, identical to the back-to-back x.
REQ-031 rst_ low for one cycle after 30 pixels, then 64 pixels of 200 -> single IN_START, all x[k]=72, no earlier pulse.
REQ-032 OUT_XFC pulsed in IDLE, then 65536 dispatched blocks (forced counter acceptable) -> no state change from the spurious pulse; blk_count wraps to 0.

Source files
------------

// File: rtl/dct_block_loader.sv
// dct_block_loader: collects raster-order 8x8 pixel blocks into a ping-pong
// pair of buffers, level-shifts each pixel on the way in, and hands complete
// blocks to the DCT with a one-cycle start pulse. The next start waits for
// the DCT's transform-complete pulse.
module dct_block_loader #(
  parameter int PIX_W       = 8,
  parameter int LEVEL_SHIFT = 128
) (
  input  logic                  clock,
  input  logic                  rst_,
  input  logic [PIX_W-1:0]      pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [63:0][PIX_W:0]  x,
  output logic                  IN_START,
  input  logic                  OUT_XFC,
  output logic [15:0]           blk_count
);

  localparam int XW = PIX_W + 1;

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t                    state;
  logic [1:0][63:0][XW-1:0]  buf_q;
  logic [5:0]                wr_idx;
  logic                      wr_sel;
  logic                      rd_sel;
  logic [1:0]                full;

  logic                      accept;
  logic                      fill_done;
  logic                      xfc_done;
  logic [XW-1:0]             shifted;

  // The write buffer is free unless it still holds a block the DCT has not
  // released. Gating with rst_ keeps the loader closed while in reset.
  assign pix_ready = rst_ & ~full[wr_sel];
  assign accept    = pix_valid & pix_ready;
  assign fill_done = accept & (wr_idx == 6'd63);
  assign xfc_done  = (state == WAIT) & OUT_XFC;

  // Zero-extend to one extra bit, then subtract the offset. The result reads
  // as a two's-complement value of width PIX_W+1.
  assign shifted = {1'b0, pix_in} - XW'(LEVEL_SHIFT);

  // Pixel storage. Contents reach x only after the buffer is marked full,
  // so the storage does not need a reset.
  always_ff @(posedge clock) begin
    if (accept) buf_q[wr_sel][wr_idx] <= shifted;
  end

  // Write side: index wraps 63 -> 0 naturally, and the buffer flips on fill.
  always_ff @(posedge clock) begin
    if (!rst_) begin
      wr_idx <= '0;
      wr_sel <= 1'b0;
    end else if (accept) begin
      wr_idx <= wr_idx + 6'd1;
      if (fill_done) wr_sel <= ~wr_sel;
    end
  end

  // Full flags. A fill and a release on the same edge always target
  // different buffers: the released one is full, so it cannot be written.
  always_ff @(posedge clock) begin
    if (!rst_) begin
      full <= '0;
    end else begin
      if (fill_done) full[wr_sel] <= 1'b1;
      if (xfc_done)  full[rd_sel] <= 1'b0;
    end
  end

  // Dispatch FSM. x is captured on entry to START, so it stays frozen while
  // the DCT works, even as the other buffer keeps filling.
  always_ff @(posedge clock) begin
    if (!rst_) begin
      state     <= IDLE;
      rd_sel    <= 1'b0;
      IN_START  <= 1'b0;
      blk_count <= '0;
      x         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (full[rd_sel]) begin
            state    <= START;
            IN_START <= 1'b1;
            x        <= buf_q[rd_sel];
          end
        end
        START: begin
          state     <= WAIT;
          IN_START  <= 1'b0;
          blk_count <= blk_count + 16'd1;
        end
        WAIT: begin
          if (OUT_XFC) begin
            state  <= IDLE;
            rd_sel <= ~rd_sel;
          end
        end
        default: begin
          state    <= IDLE;
          IN_START <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dct_block_loader.sv
// tb_dct_block_loader: table-driven block vectors, hand-written corner
// sequences and a randomized run, all checked against a queue-based model
// of filled blocks and scheduled start times.
module tb_dct_block_loader;

  logic             clock = 1'b0;
  logic             rst_ = 1'b0;
  logic [7:0]       pix_in = '0;
  logic             pix_valid = 1'b0;
  logic             OUT_XFC = 1'b0;
  logic             pix_ready;
  logic             IN_START;
  logic [63:0][8:0] x;
  logic [15:0]      blk_count;

  dct_block_loader #(.PIX_W(8), .LEVEL_SHIFT(128)) dut (
    .clock     (clock),
    .rst_      (rst_),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .x         (x),
    .IN_START  (IN_START),
    .OUT_XFC   (OUT_XFC),
    .blk_count (blk_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: accepted pixels of the block being filled, filled
  // blocks not yet released (oldest first, 64 values each), and the cycle
  // at which the next start pulse is due.
  int               part[$];
  int               pend[$];
  int               npend;
  bit               inflight;
  int               next_start;
  int               cyc;
  logic [15:0]      mcount;
  logic [63:0][8:0] x_exp;
  bit               saw_start;

  typedef struct {
    int base;
    int step;
    bit tog;
    int e0;
    int e1;
    int e63;
  } vec_t;

  vec_t vecs[8];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chki(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chkx(logic [63:0][8:0] act, logic [63:0][8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL x: got %h expected %h (cycle %0d)", act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    part.delete();
    pend.delete();
    npend      = 0;
    inflight   = 1'b0;
    next_start = -1;
    mcount     = '0;
    x_exp      = '0;
  endfunction

  // One clock cycle: drive inputs, check every output at the negedge,
  // then advance the model to what the coming rising edge does.
  task automatic cycle(input bit r, input bit v, input logic [7:0] p, input bit xf);
    bit er;
    bit es;
    rst_ = r; pix_valid = v; pix_in = p; OUT_XFC = xf;
    @(negedge clock);
    er = r && (npend < 2);
    es = r && (cyc == next_start);
    if (es) for (int k = 0; k < 64; k++) x_exp[k] = 9'(pend[k]);
    chk("pix_ready", 64'(pix_ready), 64'(er));
    chk("IN_START", 64'(IN_START), 64'(es));
    chk("blk_count", 64'(blk_count), 64'(mcount));
    chkx(x, x_exp);
    saw_start = IN_START;
    if (!r) begin
      model_reset();
    end else begin
      if (es) begin
        mcount     = mcount + 16'd1;
        inflight   = 1'b1;
        next_start = -1;
      end else if (inflight && xf) begin
        repeat (64) void'(pend.pop_front());
        npend--;
        inflight = 1'b0;
      end
      if (v && er) begin
        part.push_back(int'(p) - 128);
        if (part.size() == 64) begin
          foreach (part[k]) pend.push_back(part[k]);
          part.delete();
          npend++;
        end
      end
      if (!inflight && next_start < 0 && npend > 0) next_start = cyc + 2;
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  // Feed one block, wait for its start, check the table values, then release.
  task automatic run_vec(input vec_t t, input int exp_cnt);
    int guard;
    int dly;
    logic [7:0] p;
    guard = 0;
    saw_start = 1'b0;
    while (npend == 0 && guard < 400) begin
      p = 8'((t.base + t.step * part.size()) & 255);
      cycle(1'b1, t.tog ? (guard % 2 == 0) : 1'b1, p, 1'b0);
      guard++;
    end
    chki("fill_timeout", (guard < 400) ? 1 : 0, 1);
    dly = 0;
    while (!saw_start && dly < 10) begin
      cycle(1'b1, 1'b0, 8'd0, 1'b0);
      dly++;
    end
    chki("start_delay", dly, 2);
    chki("x0", int'($signed(x[0])), t.e0);
    chki("x1", int'($signed(x[1])), t.e1);
    chki("x63", int'($signed(x[63])), t.e63);
    chk("blk_after", 64'(blk_count), 64'(exp_cnt));
    repeat (3) cycle(1'b1, 1'b0, 8'd0, 1'b0);
    cycle(1'b1, 1'b0, 8'd0, 1'b1);
    cycle(1'b1, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{128, 0,   1'b0,    0,    0,    0};
    vecs[1] = '{0,   4,   1'b0, -128, -124,  124};
    vecs[2] = '{128, 0,   1'b1,    0,    0,    0};
    vecs[3] = '{200, 0,   1'b0,   72,   72,   72};
    vecs[4] = '{0,   0,   1'b0, -128, -128, -128};
    vecs[5] = '{255, 0,   1'b1,  127,  127,  127};
    vecs[6] = '{64,  1,   1'b0,  -64,  -63,   -1};
    vecs[7] = '{255, 255, 1'b0,  127,  126,   64};

    rst_ = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    cyc = 0;
    do_reset();

    // Table vectors; entry 3 is preceded by a discarded partial block.
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        do_reset();
        repeat (30) cycle(1'b1, 1'b1, 8'($urandom), 1'b0);
        cycle(1'b0, 1'b1, 8'd200, 1'b0);
      end else begin
        do_reset();
      end
      run_vec(vecs[i], 1);
    end

    // Back-pressure: three blocks offered, completion withheld.
    do_reset();
    repeat (140) cycle(1'b1, 1'b1, 8'($urandom), 1'b0);
    chk("ready_stalled", 64'(pix_ready), 64'(0));
    chki("accepted", part.size() + 64 * npend, 128);
    cycle(1'b1, 1'b1, 8'($urandom), 1'b1);
    chk("ready_after_xfc", 64'(pix_ready), 64'(1));
    cycle(1'b1, 1'b1, 8'($urandom), 1'b0);
    chk("start_blk2", 64'(IN_START), 64'(1));
    cycle(1'b1, 1'b1, 8'($urandom), 1'b0);
    chk("blk_count_2", 64'(blk_count), 64'(2));

    // Spurious completion pulses in IDLE, then counter wrap.
    do_reset();
    cycle(1'b1, 1'b0, 8'd0, 1'b1);
    cycle(1'b1, 1'b0, 8'd0, 1'b1);
    run_vec(vecs[0], 1);
    force dut.blk_count = 16'hFFFF;
    release dut.blk_count;
    mcount = 16'hFFFF;
    run_vec(vecs[1], 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++)
      cycle(1'b1, ($urandom % 4) != 0, 8'($urandom), ($urandom % 8) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
